vending_input_conditioner: RTL and testbench



---
 rtl/vending_input_conditioner.sv | 154 +++++++++++++++
 tb/tb_vending_input_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vending_input_conditioner.sv
// Button front-end for the vending FSM: polarity fix, 2-FF synchronizer,
// per-channel debounce, press capture and a fixed-priority pulse arbiter.
// Channel order everywhere: bit 0 = coin, bit 1 = coffee, bit 2 = sprite.
module vending_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_coin,
    input  logic i_btn_coffee,
    input  logic i_btn_sprite,
    output logic o_coin,
    output logic o_coffee,
    output logic o_sprite,
    output logic o_busy
);

    localparam int unsigned NCH   = 3;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    // Counter value on which the next mismatching sample completes the debounce window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam bit               HAS_GAP  = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1
    } state_t;

    logic [NCH-1:0]   btn_c;
    logic [NCH-1:0]   sync_q1;
    logic [NCH-1:0]   sync_q2;
    logic [CNT_W-1:0] db_cnt [NCH];
    logic [NCH-1:0]   stable;
    logic [NCH-1:0]   rise_c;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   grant_c;
    logic [NCH-1:0]   clr_c;
    logic [NCH-1:0]   req;
    logic [GAP_W-1:0] gap_cnt;
    logic             busy;
    state_t           state;

    // Normalise to "1 = pressed" ahead of the synchronizer.
    assign btn_c = {i_btn_sprite, i_btn_coffee, i_btn_coin} ^ {NCH{BTN_ACTIVE_LOW}};

    // Two-stage synchronizer; only the second stage feeds the logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_c;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: stable follows the synced level once it has differed for the full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync_q2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press detect: stable is about to rise on this edge.
    always_comb begin
        rise_c = '0;
        for (int i = 0; i < NCH; i++) begin
            rise_c[i] = ~stable[i] & sync_q2[i] & (db_cnt[i] == CNT_LAST);
        end
    end

    // Fixed priority coin > coffee > sprite; a grant only consumes pending when IDLE.
    always_comb begin
        grant_c = '0;
        if (pending[0]) begin
            grant_c = 3'b001;
        end else if (pending[1]) begin
            grant_c = 3'b010;
        end else if (pending[2]) begin
            grant_c = 3'b100;
        end
        clr_c = (state == ST_IDLE) ? grant_c : '0;
    end

    // Pending flags; a new press on the same edge as its issue keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_c) | rise_c;
        end
    end

    // Arbiter FSM: one-cycle pulse from IDLE, then GAP_CYCLES forced idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            req     <= '0;
            busy    <= 1'b0;
        end else begin
            req  <= '0;
            busy <= (state != ST_IDLE) | (|pending);
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        req <= grant_c;
                        if (HAS_GAP) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

    assign o_coin   = req[0];
    assign o_coffee = req[1];
    assign o_sprite = req[2];
    assign o_busy   = busy;

endmodule

// File: tb/tb_vending_input_conditioner.sv
// Bench for vending_input_conditioner: four instances (default gap, zero gap,
// active-low buttons, long gap) driven separately; expected pulses queued per
// instance as {cycle, channel} and matched as the outputs appear.
module tb_vending_input_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Per-instance buttons: a = D4/G2, g = D4/G0, n = D4/G2 active-low, l = D4/G60
    logic a_coin, a_coffee, a_sprite;
    logic g_coin, g_coffee, g_sprite;
    logic n_coin, n_coffee, n_sprite;
    logic l_coin, l_coffee, l_sprite;
    logic [2:0] outs [4];
    logic       busy [4];

    // Expected pulses per instance, encoded cycle*4 + channel.
    int q [4][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    vending_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .BTN_ACTIVE_LOW(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_btn_coin(a_coin), .i_btn_coffee(a_coffee), .i_btn_sprite(a_sprite),
        .o_coin(outs[0][0]), .o_coffee(outs[0][1]), .o_sprite(outs[0][2]), .o_busy(busy[0])
    );

    vending_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(0), .BTN_ACTIVE_LOW(1'b0)) u_dut_g (
        .clk(clk), .rst_n(rst_n),
        .i_btn_coin(g_coin), .i_btn_coffee(g_coffee), .i_btn_sprite(g_sprite),
        .o_coin(outs[1][0]), .o_coffee(outs[1][1]), .o_sprite(outs[1][2]), .o_busy(busy[1])
    );

    vending_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .BTN_ACTIVE_LOW(1'b1)) u_dut_n (
        .clk(clk), .rst_n(rst_n),
        .i_btn_coin(n_coin), .i_btn_coffee(n_coffee), .i_btn_sprite(n_sprite),
        .o_coin(outs[2][0]), .o_coffee(outs[2][1]), .o_sprite(outs[2][2]), .o_busy(busy[2])
    );

    vending_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(60), .BTN_ACTIVE_LOW(1'b0)) u_dut_l (
        .clk(clk), .rst_n(rst_n),
        .i_btn_coin(l_coin), .i_btn_coffee(l_coffee), .i_btn_sprite(l_sprite),
        .o_coin(outs[3][0]), .o_coffee(outs[3][1]), .o_sprite(outs[3][2]), .o_busy(busy[3])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int d, input int ch, input int c);
        q[d].push_back(c * 4 + ch);
    endtask

    // Scoreboard: match every pulse to the queue head, flag overdue expectations.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (q[d].size() > 0 && (q[d][0] / 4) < cyc) begin
                check($sformatf("missing_pulse_d%0d_ch%0d", d, q[d][0] % 4), cyc, q[d][0] / 4);
                void'(q[d].pop_front());
            end
            if (outs[d] != 3'b000) begin
                check($sformatf("onehot_d%0d", d), $countones(outs[d]), 1);
                if (q[d].size() == 0) begin
                    check($sformatf("unexpected_pulse_d%0d", d), int'(outs[d]), 0);
                end else begin
                    int e;
                    logic [2:0] exp_v;
                    e = q[d].pop_front();
                    exp_v = 3'b001 << (e % 4);
                    check($sformatf("pulse_ch_d%0d", d), int'(outs[d]), int'(exp_v));
                    check($sformatf("pulse_cyc_d%0d", d), cyc, e / 4);
                end
            end
        end
    end

    initial begin
        int c;
        int c2;
        rst_n = 1'b0;
        {a_coin, a_coffee, a_sprite} = 3'b000;
        {g_coin, g_coffee, g_sprite} = 3'b000;
        {n_coin, n_coffee, n_sprite} = 3'b111;
        {l_coin, l_coffee, l_sprite} = 3'b000;

        // Reset state of every instance
        tick(1);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_outs_d%0d", d), int'(outs[d]), 0);
            check($sformatf("rst_busy_d%0d", d), int'(busy[d]), 0);
        end
        tick(2);
        rst_n = 1'b1;
        tick(5);

        // Clean coin press held 20 cycles: pulse at +7, busy low 3 cycles later
        c = cyc;
        a_coin = 1'b1;
        push(0, 0, c + 7);
        tick(9);
        check("t1_busy_gap", int'(busy[0]), 1);
        tick(1);
        check("t1_busy_idle", int'(busy[0]), 0);
        tick(10);
        a_coin = 1'b0;
        tick(12);

        // Bouncing press then held: one pulse 7 cycles after the last rising sample
        a_coin = 1'b1; tick(2);
        a_coin = 1'b0; tick(2);
        a_coin = 1'b1; tick(2);
        a_coin = 1'b0; tick(2);
        c = cyc;
        a_coin = 1'b1;
        push(0, 0, c + 7);
        tick(15);
        a_coin = 1'b0;
        tick(12);

        // 3-cycle glitch: no pulse
        a_coin = 1'b1; tick(3);
        a_coin = 1'b0; tick(12);
        check("glitch_busy", int'(busy[0]), 0);

        // Coin and coffee together: priority order, separated by the gap
        c = cyc;
        a_coin = 1'b1; a_coffee = 1'b1;
        push(0, 0, c + 7);
        push(0, 1, c + 10);
        tick(20);
        a_coin = 1'b0; a_coffee = 1'b0;
        tick(12);

        // Same with zero gap: back-to-back pulses
        c = cyc;
        g_coin = 1'b1; g_coffee = 1'b1;
        push(1, 0, c + 7);
        push(1, 1, c + 8);
        tick(20);
        g_coin = 1'b0; g_coffee = 1'b0;
        tick(12);

        // Sprite held 100 cycles, released 10, pressed again
        c = cyc;
        a_sprite = 1'b1;
        push(0, 2, c + 7);
        tick(100);
        a_sprite = 1'b0;
        tick(10);
        c2 = cyc;
        a_sprite = 1'b1;
        push(0, 2, c2 + 7);
        tick(20);
        a_sprite = 1'b0;
        tick(12);

        // Three coin presses inside one long gap collapse into one extra pulse
        c = cyc;
        l_coin = 1'b1;
        push(3, 0, c + 7);
        push(3, 0, c + 68);
        tick(8);
        l_coin = 1'b0;
        tick(8);
        for (int k = 0; k < 3; k++) begin
            l_coin = 1'b1; tick(8);
            l_coin = 1'b0; tick(8);
        end
        tick(12);
        check("collapse_busy_gap", int'(busy[3]), 1);

        // Reset while in GAP with coffee pending: coffee is discarded
        c = cyc;
        a_coin = 1'b1; a_coffee = 1'b1;
        push(0, 0, c + 7);
        tick(8);
        rst_n = 1'b0;
        a_coin = 1'b0; a_coffee = 1'b0;
        #1;
        check("rst_mid_outs", int'(outs[0]), 0);
        check("rst_mid_busy", int'(busy[0]), 0);
        tick(3);
        check("rst_hold_busy", int'(busy[0]), 0);
        rst_n = 1'b1;
        tick(25);
        check("post_rst_busy", int'(busy[0]), 0);
        check("post_rst_queue", q[0].size(), 0);
        c = cyc;
        a_coffee = 1'b1;
        push(0, 1, c + 7);
        tick(12);
        a_coffee = 1'b0;
        tick(12);

        // Active-low buttons: idle-high gives nothing, a 10-cycle low gives one coin
        check("al_idle_busy", int'(busy[2]), 0);
        c = cyc;
        n_coin = 1'b0;
        push(2, 0, c + 7);
        tick(10);
        n_coin = 1'b1;
        tick(15);

        for (int d = 0; d < 4; d++) begin
            check($sformatf("queue_empty_d%0d", d), q[d].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
